tl_inflight_tracker: RTL and testbench
======================================

# tl_inflight_tracker

Tracks outstanding TileLink-UL/UH requests per source ID between a master's A channel and a slave's D channel. Produces registered protocol-error pulses and an in-flight summary for the downstream TileLink assertion monitor. The monitor consumes these flags and turns them into `$fatal` or printf checks. The block is testbench-only, non-intrusive, and never drives the bus.

## Interface

Parameters:
- `SOURCE_BITS`, default 2: source ID width; the table has 2^SOURCE_BITS entries.
- `SIZE_BITS`, default 3: width of `a_size` and `d_size` (log2 bytes).
- `BEAT_LOG2`, default 2: log2 of the bus beat width in bytes.
- `TIMEOUT`, default 4096: watchdog limit in cycles, range 1..65535.

Ports (direction, width, meaning):
- `clock`, in, 1: sole clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `a_valid`, `a_ready`, in, 1 each: A-channel handshake. A beat fires when both are 1.
- `a_opcode`, in, 3: A opcode.
- `a_source`, in, SOURCE_BITS: A source ID.
- `a_size`, in, SIZE_BITS: A transfer size.
- `d_valid`, `d_ready`, in, 1 each: D-channel handshake. A beat fires when both are 1.
- `d_opcode`, in, 3: D opcode.
- `d_source`, in, SOURCE_BITS: D source ID.
- `d_size`, in, SIZE_BITS: D transfer size.
- `inflight_mask`, out, 2^SOURCE_BITS: one bit per outstanding source.
- `inflight_cnt`, out, SOURCE_BITS+1: population count of `inflight_mask`.
- `err_a_dup`, out, 1: A first beat used a source that is already in flight.
- `err_d_unexp`, out, 1: D first beat arrived for a source that is not in flight.
- `err_d_opcode`, out, 1: D opcode is not the expected response for the stored request.
- `err_d_size`, out, 1: `d_size` differs from the stored size.
- `err_burst`, out, 1: opcode, source or size changed in the middle of a burst.
- `err_timeout`, out, 1: watchdog expired. Sticky.

## Operation

Beat count:
- beats = 1 when size ≤ BEAT_LOG2, otherwise 2^(size−BEAT_LOG2).
- A channel: multi-beat only for PutFull (0) and PutPartial (1). All other A opcodes are 1 beat.
- D channel: multi-beat only for AccessAckData (1). All other D opcodes are 1 beat.

Per-channel beat counters:
- Each channel has a counter holding beats remaining, 0 when idle.
- On the first beat the counter loads beats−1 and the block latches opcode, source and size.
- Each later fired beat decrements the counter.
- A fired beat whose fields differ from the latched values raises `err_burst`.

Per-source table:
- Each entry holds {valid, opcode, size}.
- The first A beat sets the entry.
- The last D beat clears the entry.

Expected D opcode for each A opcode:
- Get (4) → AccessAckData (1).
- PutFull (0) → AccessAck (0).
- PutPartial (1) → AccessAck (0).
- Arithmetic (2) → AccessAckData (1).
- Logical (3) → AccessAckData (1).
- Intent/Hint (5) → HintAck (2).

Checks on the D first beat:
- `err_d_opcode` and `err_d_size` are evaluated against the table entry, or against a same-cycle A first beat with the same source.
- Neither is raised when `err_d_unexp` is raised.

Boundary cases:
- Same-cycle A first beat and D last beat on the same source, with the entry valid: clear and set both apply, and the net entry is valid with the new A fields.
- Same-cycle A first beat and D last beat on the same source, with the entry invalid: a zero-latency response. Treated as matched, no error, net entry invalid.
- A first beat on a valid source: `err_a_dup` pulses and the entry is overwritten.
- D first beat on an invalid source: `err_d_unexp` pulses and the table is unchanged.
- `d_valid` without `d_ready` is not a beat. Stalls never change state.

Reset:
- Clears the table, both beat counters, every error output, the watchdog, and `inflight_*`.
- A burst in progress when reset asserts is discarded.
- The first beat after reset deasserts is treated as a first beat.

## Timing

- All outputs are registered. The reset value of every output is 0.
- `err_*` (except `err_timeout`) pulse high for exactly one cycle, in cycle N+1, for an offending fire in cycle N.
- `inflight_mask` and `inflight_cnt` reflect fires of cycle N in cycle N+1.
- Zero combinational paths from inputs to outputs.
- Full throughput: the block accepts an A beat and a D beat every cycle.

## Configuration

Macro `TL_INFLIGHT_WATCHDOG_EN`.

When defined:
- A 16-bit counter increments on every cycle where `inflight_mask` ≠ 0 and no D beat fires.
- It clears on any D fire or when `inflight_mask` = 0.
- When the counter reaches `TIMEOUT`, `err_timeout` sets on the next cycle and holds until `reset`.
- The counter saturates at `TIMEOUT`.

When undefined:
- No counter is instantiated.
- `err_timeout` is constant 0.

## Test plan

- **Single Get:** Get src=1 size=2 → mask=0b0010 next cycle. AccessAckData src=1 size=2 → mask=0, no errors.
- **Put burst, BEAT_LOG2=2:** PutFull src=0 size=4 (4 beats) with `a_valid` gaps → one entry set. AccessAck src=0 size=4 (1 beat) → clear. Changing `a_source` on beat 3 → `err_burst`=1 for one cycle.
- **Duplicate and unexpected:** Get src=2 twice with no response → `err_a_dup` pulse. AccessAck src=3 with nothing outstanding → `err_d_unexp` pulse, mask unchanged.
- **Mismatch:** Get src=0 size=2 answered by AccessAck size=2 → `err_d_opcode`. Answered by AccessAckData size=3 → `err_d_size` only.
- **Same-cycle:** Get src=1 and AccessAckData src=1 fire together with the entry invalid → no error, mask=0. With the entry valid → mask bit stays 1.
- **Reset mid-burst and watchdog** (with macro, TIMEOUT=8):
  - Reset during beat 2 of a 4-beat Put → all outputs 0. The next single-beat Put is accepted cleanly.
  - Get with no response → `err_timeout`=1 at cycle 9 after the fire, held until reset.

Source files
------------

// File: rtl/tl_inflight_tracker.sv
// Per-source TileLink-UL/UH in-flight tracker with registered protocol-error pulses.
// Optional watchdog enabled by defining TL_INFLIGHT_WATCHDOG_EN.
module tl_inflight_tracker #(
  parameter int SOURCE_BITS = 2,
  parameter int SIZE_BITS   = 3,
  parameter int BEAT_LOG2   = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic                     a_ready,
  input  logic [2:0]               a_opcode,
  input  logic [SOURCE_BITS-1:0]   a_source,
  input  logic [SIZE_BITS-1:0]     a_size,
  input  logic                     d_valid,
  input  logic                     d_ready,
  input  logic [2:0]               d_opcode,
  input  logic [SOURCE_BITS-1:0]   d_source,
  input  logic [SIZE_BITS-1:0]     d_size,
  output logic [(1<<SOURCE_BITS)-1:0] inflight_mask,
  output logic [SOURCE_BITS:0]     inflight_cnt,
  output logic                     err_a_dup,
  output logic                     err_d_unexp,
  output logic                     err_d_opcode,
  output logic                     err_d_size,
  output logic                     err_burst,
  output logic                     err_timeout
);
  localparam int N  = 1 << SOURCE_BITS;
  localparam int CW = 1 << SIZE_BITS;

  typedef struct packed {
    logic                 vld;
    logic [2:0]           opc;
    logic [SIZE_BITS-1:0] size;
  } ent_t;

  function automatic logic [CW-1:0] beats_m1(input logic multi, input logic [SIZE_BITS-1:0] size);
    logic [CW-1:0] r;
    r = '0;
    if (multi && int'(size) > BEAT_LOG2) r = (CW'(1) << (int'(size) - BEAT_LOG2)) - CW'(1);
    return r;
  endfunction

  function automatic logic [2:0] exp_d(input logic [2:0] a_opc);
    logic [2:0] r;
    case (a_opc)
      3'd0, 3'd1:       r = 3'd0;
      3'd2, 3'd3, 3'd4: r = 3'd1;
      3'd5:             r = 3'd2;
      default:          r = 3'd7; // undefined A opcodes never match a legal response
    endcase
    return r;
  endfunction

  ent_t                   tbl [N];
  logic [CW-1:0]          a_cnt, d_cnt;
  logic [2:0]             a_lopc, d_lopc;
  logic [SOURCE_BITS-1:0] a_lsrc, d_lsrc;
  logic [SIZE_BITS-1:0]   a_lsize, d_lsize;

  logic a_fire, d_fire, a_first, d_first, d_last, same_src;
  logic [CW-1:0] a_bm1, d_bm1;
  logic d_hit_tbl, d_hit_a, unexp, opc_bad, size_bad, dup, zero_lat, a_brst, d_brst;
  logic [2:0] ref_opc;
  logic [SIZE_BITS-1:0] ref_size;
  logic [N-1:0] set_v, clr_v, nxt_vld;
  logic [SOURCE_BITS:0] nxt_cnt;

  assign a_fire   = a_valid && a_ready;
  assign d_fire   = d_valid && d_ready;
  assign a_first  = a_fire && (a_cnt == '0);
  assign d_first  = d_fire && (d_cnt == '0);
  assign a_bm1    = beats_m1(a_opcode == 3'd0 || a_opcode == 3'd1, a_size);
  assign d_bm1    = beats_m1(d_opcode == 3'd1, d_size);
  assign d_last   = d_fire && (d_first ? (d_bm1 == '0) : (d_cnt == CW'(1)));
  assign same_src = (a_source == d_source);

  // A stored entry takes precedence; a same-cycle A first beat covers zero-latency responses.
  assign d_hit_tbl = tbl[d_source].vld;
  assign d_hit_a   = a_first && same_src;
  assign ref_opc   = d_hit_tbl ? tbl[d_source].opc  : a_opcode;
  assign ref_size  = d_hit_tbl ? tbl[d_source].size : a_size;
  assign unexp     = d_first && !d_hit_tbl && !d_hit_a;
  assign opc_bad   = d_first && !unexp && (d_opcode != exp_d(ref_opc));
  assign size_bad  = d_first && !unexp && (d_size != ref_size);
  assign zero_lat  = a_first && d_last && same_src && !tbl[a_source].vld;
  // A request reusing a source retired by this cycle's D last beat is legal.
  assign dup       = a_first && tbl[a_source].vld && !(d_last && same_src);

  assign a_brst = a_fire && !a_first &&
                  (a_opcode != a_lopc || a_source != a_lsrc || a_size != a_lsize);
  assign d_brst = d_fire && !d_first &&
                  (d_opcode != d_lopc || d_source != d_lsrc || d_size != d_lsize);

  always_comb begin
    set_v   = '0;
    clr_v   = '0;
    nxt_vld = '0;
    nxt_cnt = '0;
    for (int i = 0; i < N; i++) begin
      set_v[i]   = a_first && (a_source == SOURCE_BITS'(i)) && !zero_lat;
      clr_v[i]   = d_last && (d_source == SOURCE_BITS'(i));
      nxt_vld[i] = set_v[i] || (tbl[i].vld && !clr_v[i]);
      nxt_cnt    = nxt_cnt + (SOURCE_BITS+1)'(nxt_vld[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_cnt <= '0; d_cnt <= '0;
      a_lopc <= '0; a_lsrc <= '0; a_lsize <= '0;
      d_lopc <= '0; d_lsrc <= '0; d_lsize <= '0;
      for (int i = 0; i < N; i++) tbl[i] <= '0;
      inflight_mask <= '0;
      inflight_cnt  <= '0;
      err_a_dup <= 1'b0; err_d_unexp <= 1'b0; err_d_opcode <= 1'b0;
      err_d_size <= 1'b0; err_burst <= 1'b0;
    end else begin
      if (a_first) begin
        a_cnt <= a_bm1; a_lopc <= a_opcode; a_lsrc <= a_source; a_lsize <= a_size;
      end else if (a_fire) a_cnt <= a_cnt - CW'(1);
      if (d_first) begin
        d_cnt <= d_bm1; d_lopc <= d_opcode; d_lsrc <= d_source; d_lsize <= d_size;
      end else if (d_fire) d_cnt <= d_cnt - CW'(1);
      for (int i = 0; i < N; i++) begin
        if (set_v[i])      tbl[i] <= '{vld: 1'b1, opc: a_opcode, size: a_size};
        else if (clr_v[i]) tbl[i].vld <= 1'b0;
      end
      inflight_mask <= nxt_vld;
      inflight_cnt  <= nxt_cnt;
      err_a_dup    <= dup;
      err_d_unexp  <= unexp;
      err_d_opcode <= opc_bad;
      err_d_size   <= size_bad;
      err_burst    <= a_brst || d_brst;
    end
  end

`ifdef TL_INFLIGHT_WATCHDOG_EN
  logic [15:0] wd_cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (d_fire || inflight_mask == '0) wd_cnt <= '0;
      else if (wd_cnt != 16'(TIMEOUT))   wd_cnt <= wd_cnt + 16'd1;
      if (wd_cnt == 16'(TIMEOUT)) err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_tl_inflight_tracker.sv
// Directed bench for tl_inflight_tracker: one linear stimulus sequence with immediate-assert checks.
module tb_tl_inflight_tracker;
`ifdef TL_INFLIGHT_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       a_valid, a_ready, d_valid, d_ready;
  logic [2:0] a_opcode, d_opcode, a_size, d_size;
  logic [1:0] a_source, d_source;
  logic [3:0] inflight_mask;
  logic [2:0] inflight_cnt;
  logic       err_a_dup, err_d_unexp, err_d_opcode, err_d_size, err_burst, err_timeout;

  int n_pass = 0;
  int n_tot  = 0;

  tl_inflight_tracker #(.SOURCE_BITS(2), .SIZE_BITS(3), .BEAT_LOG2(2), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_source(a_source), .a_size(a_size),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source), .d_size(d_size),
    .inflight_mask(inflight_mask), .inflight_cnt(inflight_cnt),
    .err_a_dup(err_a_dup), .err_d_unexp(err_d_unexp), .err_d_opcode(err_d_opcode),
    .err_d_size(err_d_size), .err_burst(err_burst), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, then sample #1 after the edge that consumes them.
  task automatic drv(input logic av, input logic [2:0] aop, input logic [1:0] asrc, input logic [2:0] asz,
                     input logic dv, input logic [2:0] dop, input logic [1:0] dsrc, input logic [2:0] dsz);
    a_valid = av; a_opcode = aop; a_source = asrc; a_size = asz;
    d_valid = dv; d_opcode = dop; d_source = dsrc; d_size = dsz;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 3'd0, 2'd0, 3'd0, 1'b0, 3'd0, 2'd0, 3'd0);
  endtask

  task automatic a_only(input logic [2:0] op, input logic [1:0] src, input logic [2:0] sz);
    drv(1'b1, op, src, sz, 1'b0, 3'd0, 2'd0, 3'd0);
  endtask

  task automatic d_only(input logic [2:0] op, input logic [1:0] src, input logic [2:0] sz);
    drv(1'b0, 3'd0, 2'd0, 3'd0, 1'b1, op, src, sz);
  endtask

  // e = {dup, unexp, d_opcode, d_size, burst, timeout}
  task automatic chk(input string tag, input logic [3:0] m, input logic [2:0] c, input logic [5:0] e);
    logic [12:0] obs, req;
    obs = {inflight_mask, inflight_cnt, err_a_dup, err_d_unexp, err_d_opcode, err_d_size, err_burst, err_timeout};
    req = {m, c, e};
    n_tot++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s: observed=%b required=%b", tag, obs, req);
  endtask

  initial begin
    reset = 1'b1; a_ready = 1'b1; d_ready = 1'b1;
    a_valid = 1'b0; a_opcode = '0; a_source = '0; a_size = '0;
    d_valid = 1'b0; d_opcode = '0; d_source = '0; d_size = '0;
    idle(); idle();
    chk("reset", 4'b0000, 3'd0, 6'b000000);
    reset = 1'b0;

    // Single Get / AccessAckData
    a_only(3'd4, 2'd1, 3'd2);  chk("get_set",   4'b0010, 3'd1, 6'b0);
    d_only(3'd1, 2'd1, 3'd2);  chk("get_clear", 4'b0000, 3'd0, 6'b0);

    // 4-beat PutFull with gaps, 1-beat AccessAck
    a_only(3'd0, 2'd0, 3'd4);  chk("put_b1",  4'b0001, 3'd1, 6'b0);
    idle();                    chk("put_gap", 4'b0001, 3'd1, 6'b0);
    a_only(3'd0, 2'd0, 3'd4);  chk("put_b2",  4'b0001, 3'd1, 6'b0);
    idle();
    a_only(3'd0, 2'd0, 3'd4);
    a_only(3'd0, 2'd0, 3'd4);  chk("put_b4",  4'b0001, 3'd1, 6'b0);
    d_only(3'd0, 2'd0, 3'd4);  chk("put_ack", 4'b0000, 3'd0, 6'b0);

    // Source changes on beat 3
    a_only(3'd0, 2'd0, 3'd4);
    a_only(3'd0, 2'd0, 3'd4);
    a_only(3'd0, 2'd1, 3'd4);  chk("burst_err",  4'b0001, 3'd1, 6'b000010);
    a_only(3'd0, 2'd0, 3'd4);  chk("burst_once", 4'b0001, 3'd1, 6'b000000);
    d_only(3'd0, 2'd0, 3'd4);  chk("burst_ack",  4'b0000, 3'd0, 6'b0);

    // Duplicate and unexpected
    a_only(3'd4, 2'd2, 3'd2);  chk("dup_first", 4'b0100, 3'd1, 6'b000000);
    a_only(3'd4, 2'd2, 3'd2);  chk("dup_err",   4'b0100, 3'd1, 6'b100000);
    idle();                    chk("dup_pulse", 4'b0100, 3'd1, 6'b000000);
    d_only(3'd0, 2'd3, 3'd2);  chk("unexp",     4'b0100, 3'd1, 6'b010000);
    d_only(3'd1, 2'd2, 3'd2);  chk("dup_clear", 4'b0000, 3'd0, 6'b000000);

    // Opcode mismatch, then size mismatch on a 2-beat AccessAckData
    a_only(3'd4, 2'd0, 3'd2);
    d_only(3'd0, 2'd0, 3'd2);  chk("opc_err",   4'b0000, 3'd0, 6'b001000);
    a_only(3'd4, 2'd0, 3'd2);
    d_only(3'd1, 2'd0, 3'd3);  chk("size_err",  4'b0001, 3'd1, 6'b000100);
    d_only(3'd1, 2'd0, 3'd3);  chk("size_last", 4'b0000, 3'd0, 6'b000000);

    // Same-cycle A first / D last on the same source
    drv(1'b1, 3'd4, 2'd1, 3'd2, 1'b1, 3'd1, 2'd1, 3'd2);  chk("zero_lat", 4'b0000, 3'd0, 6'b0);
    a_only(3'd4, 2'd1, 3'd2);
    drv(1'b1, 3'd4, 2'd1, 3'd2, 1'b1, 3'd1, 2'd1, 3'd2);  chk("same_valid", 4'b0010, 3'd1, 6'b0);
    d_only(3'd1, 2'd1, 3'd2);  chk("same_clear", 4'b0000, 3'd0, 6'b0);

    // D stall is not a beat
    a_only(3'd4, 2'd3, 3'd2);
    d_ready = 1'b0;
    d_only(3'd1, 2'd3, 3'd2);  chk("stall",      4'b1000, 3'd1, 6'b0);
    d_ready = 1'b1;
    d_only(3'd1, 2'd3, 3'd2);  chk("stall_done", 4'b0000, 3'd0, 6'b0);

    // Reset during beat 2 of a 4-beat Put, then a clean single-beat Put
    a_only(3'd0, 2'd0, 3'd4);
    reset = 1'b1;
    a_only(3'd0, 2'd0, 3'd4);  chk("rst_mid",   4'b0000, 3'd0, 6'b0);
    reset = 1'b0;
    a_only(3'd0, 2'd2, 3'd2);  chk("rst_put",   4'b0100, 3'd1, 6'b0);
    d_only(3'd0, 2'd2, 3'd2);  chk("rst_ack",   4'b0000, 3'd0, 6'b0);

    // Watchdog: Get with no response, TIMEOUT=8
    a_only(3'd4, 2'd1, 3'd2);  chk("wd_fire",   4'b0010, 3'd1, 6'b0);
    for (int k = 1; k <= 9; k++) begin
      idle();
      chk($sformatf("wd_c%0d", k), 4'b0010, 3'd1, {5'b0, WD && (k >= 9)});
    end
    d_only(3'd1, 2'd1, 3'd2);  chk("wd_sticky", 4'b0000, 3'd0, {5'b0, WD});
    reset = 1'b1;
    idle();                    chk("wd_reset",  4'b0000, 3'd0, 6'b0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
